// File: rtl/cla16_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cla4 / cla16_arbiter
// Description : cla4 is a 4-bit carry-lookahead slice. cla16_arbiter shares
//               one 16-bit adder (four cla4 slices chained through carry)
//               among NREQ requesters. Requesters are picked round-robin, and
//               each op is one of add / sub / adc / sbb. The adder result and
//               its flags go into a one-entry response register. One carry is
//               saved per requester so multi-precision chains survive
//               interleaving with other requesters.
// Ports       : clk, rst                       clock, sync active-high reset
//               req_valid/req_ready [NREQ]      per-requester handshake
//               req_x/req_y [16*NREQ]           operands, 16 bits per requester
//               req_op [2*NREQ]                 00 add, 01 sub, 10 adc, 11 sbb
//               rsp_valid/rsp_ready             response handshake
//               rsp_id, rsp_z, rsp_carry, rsp_zero, rsp_parity, rsp_sign,
//               rsp_overflow                    registered result and flags
//               saved_carry [NREQ]              per-requester carry state
// Revision    : 1.0 - initial release
// ============================================================================

module cla4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_s,
    output logic       o_cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Carries are expanded in full so that no carry waits on a previous one.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign o_cout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign o_s    = w_p ^ w_c;
endmodule

module cla16_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_x,
    input  logic [16*NREQ-1:0]   req_y,
    input  logic [2*NREQ-1:0]    req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_z,
    output logic                 rsp_carry,
    output logic                 rsp_zero,
    output logic                 rsp_parity,
    output logic                 rsp_sign,
    output logic                 rsp_overflow,
    output logic [NREQ-1:0]      saved_carry
);
    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } rsp_state_t;

    rsp_state_t       r_state;
    logic [IDW-1:0]   r_ptr;
    logic [NREQ-1:0]  r_saved_carry;
    logic [IDW-1:0]   r_rsp_id;
    logic [15:0]      r_rsp_z;
    logic             r_rsp_carry, r_rsp_zero, r_rsp_parity, r_rsp_sign, r_rsp_overflow;

    logic [15:0]      w_xa  [NREQ];
    logic [15:0]      w_ya  [NREQ];
    logic [1:0]       w_opa [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_xa[gi]  = req_x[16*gi +: 16];
            assign w_ya[gi]  = req_y[16*gi +: 16];
            assign w_opa[gi] = req_op[2*gi +: 2];
        end
    endgenerate

    // (base + k) mod NREQ with both terms already below NREQ.
    function automatic logic [IDW-1:0] f_wrap(input logic [IDW-1:0] base, input int k);
        logic [IDW:0] sum;
        sum = {1'b0, base} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(NREQ)) begin
            sum = sum - (IDW+1)'(NREQ);
        end
        return sum[IDW-1:0];
    endfunction

    logic [IDW-1:0] w_grant;
    logic           w_any;
    logic           w_can_accept;
    logic           w_accept;

    // Search from the highest offset down so the candidate nearest ptr is the
    // last one written and wins.
    always_comb begin
        w_grant = r_ptr;
        for (int k = NREQ-1; k >= 0; k--) begin
            if (req_valid[f_wrap(r_ptr, k)]) begin
                w_grant = f_wrap(r_ptr, k);
            end
        end
    end

    assign w_any        = |req_valid;
    assign w_can_accept = (r_state == S_EMPTY) | rsp_ready;
    assign w_accept     = w_can_accept & w_any & ~rst;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    // Datapath for the granted requester.
    logic [15:0] w_x, w_y, w_ye, w_z;
    logic [1:0]  w_op;
    logic        w_cin;
    logic [4:0]  w_c;
    logic        w_ovf;

    assign w_x  = w_xa[w_grant];
    assign w_y  = w_ya[w_grant];
    assign w_op = w_opa[w_grant];
    assign w_ye = w_op[0] ? ~w_y : w_y;

    always_comb begin
        case (w_op)
            2'b00:   w_cin = 1'b0;
            2'b01:   w_cin = 1'b1;
            default: w_cin = r_saved_carry[w_grant];
        endcase
    end

    assign w_c[0] = w_cin;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cla
            cla4 u_cla4 (
                .i_a    (w_x[4*gi +: 4]),
                .i_b    (w_ye[4*gi +: 4]),
                .i_cin  (w_c[gi]),
                .o_s    (w_z[4*gi +: 4]),
                .o_cout (w_c[gi+1])
            );
        end
    endgenerate

    assign w_ovf = (w_x[15] & w_ye[15] & ~w_z[15]) | (~w_x[15] & ~w_ye[15] & w_z[15]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_EMPTY;
            r_ptr          <= '0;
            r_saved_carry  <= '0;
            r_rsp_id       <= '0;
            r_rsp_z        <= '0;
            r_rsp_carry    <= 1'b0;
            r_rsp_zero     <= 1'b0;
            r_rsp_parity   <= 1'b0;
            r_rsp_sign     <= 1'b0;
            r_rsp_overflow <= 1'b0;
        end else if (w_accept) begin
            // Covers the drain-and-refill case: the old entry leaves on this
            // same edge the new one lands.
            r_state                 <= S_FULL;
            r_rsp_id                <= w_grant;
            r_rsp_z                 <= w_z;
            r_rsp_carry             <= w_c[4];
            r_rsp_zero              <= (w_z == 16'h0000);
            r_rsp_parity            <= ~^w_z;
            r_rsp_sign              <= w_z[15];
            r_rsp_overflow          <= w_ovf;
            r_saved_carry[w_grant]  <= w_c[4];
            r_ptr                   <= (w_grant == IDW'(NREQ-1)) ? '0 : w_grant + 1'b1;
        end else if (rsp_ready) begin
            r_state <= S_EMPTY;
        end
    end

    assign rsp_valid    = (r_state == S_FULL);
    assign rsp_id       = r_rsp_id;
    assign rsp_z        = r_rsp_z;
    assign rsp_carry    = r_rsp_carry;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_parity   = r_rsp_parity;
    assign rsp_sign     = r_rsp_sign;
    assign rsp_overflow = r_rsp_overflow;
    assign saved_carry  = r_saved_carry;
endmodule
`default_nettype wire

// File: tb/tb_cla16_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla16_arbiter
// Description : Self-checking bench for cla16_arbiter. A reference model
//               predicts each grant and result when the request is accepted.
//               The prediction goes into a queue and is compared when the
//               response appears. Directed checks cover the boundary cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla16_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [16*NREQ-1:0]   req_x;
    logic [16*NREQ-1:0]   req_y;
    logic [2*NREQ-1:0]    req_op;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [15:0]          rsp_z;
    logic                 rsp_carry, rsp_zero, rsp_parity, rsp_sign, rsp_overflow;
    logic [NREQ-1:0]      saved_carry;

    cla16_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_op       (req_op),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_z        (rsp_z),
        .rsp_carry    (rsp_carry),
        .rsp_zero     (rsp_zero),
        .rsp_parity   (rsp_parity),
        .rsp_sign     (rsp_sign),
        .rsp_overflow (rsp_overflow),
        .saved_carry  (saved_carry)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Flags packed as {carry, zero, parity, sign, overflow}.
    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    z;
        logic [4:0]     fl;
    } exp_t;

    exp_t q[$];
    logic            m_full;
    int              m_ptr;
    logic [NREQ-1:0] m_saved;

    function automatic exp_t model(input int id, input logic [1:0] op,
                                   input logic [15:0] x, input logic [15:0] y,
                                   input logic sc);
        exp_t        e;
        logic [15:0] ye;
        logic        cin;
        logic [16:0] s;
        ye  = op[0] ? ~y : y;
        cin = (op == 2'b00) ? 1'b0 : (op == 2'b01) ? 1'b1 : sc;
        s   = {1'b0, x} + {1'b0, ye} + {16'b0, cin};
        e.id = IDW'(id);
        e.z  = s[15:0];
        e.fl = {s[16], s[15:0] == 16'h0, ~^s[15:0], s[15],
                (x[15] & ye[15] & ~s[15]) | (~x[15] & ~ye[15] & s[15])};
        return e;
    endfunction

    // Scoreboard monitor: compares the live response, then predicts the grant
    // and result for the coming edge.
    initial begin
        exp_t            e;
        int              g;
        int              idx;
        logic            can;
        logic [NREQ-1:0] exp_rdy;
        m_full  = 1'b0;
        m_ptr   = 0;
        m_saved = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_req_ready", 32'(req_ready), 32'h0);
                q.delete();
                m_full  = 1'b0;
                m_ptr   = 0;
                m_saved = '0;
            end else begin
                check("rsp_valid", 32'(rsp_valid), 32'(m_full));
                if (m_full) begin
                    if (q.size() == 0) begin
                        check("sb_underflow", 32'h1, 32'h0);
                    end else begin
                        e = q[0];
                        check("sb_id", 32'(rsp_id), 32'(e.id));
                        check("sb_z", 32'(rsp_z), 32'(e.z));
                        check("sb_flags", 32'({rsp_carry, rsp_zero, rsp_parity, rsp_sign, rsp_overflow}),
                              32'(e.fl));
                        if (rsp_ready) void'(q.pop_front());
                    end
                end
                check("saved_carry", 32'(saved_carry), 32'(m_saved));
                can = !m_full || rsp_ready;
                g   = -1;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_ptr + k) % NREQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
                exp_rdy = (can && g >= 0) ? (NREQ'(1) << g) : '0;
                check("req_ready", 32'(req_ready), 32'(exp_rdy));
                if (can && g >= 0) begin
                    e = model(g, req_op[2*g +: 2], req_x[16*g +: 16], req_y[16*g +: 16], m_saved[g]);
                    q.push_back(e);
                    m_saved[g] = e.fl[4];
                    m_ptr      = (g + 1) % NREQ;
                    m_full     = 1'b1;
                end else if (rsp_ready) begin
                    m_full = 1'b0;
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
        req_x[16*i +: 16] = x;
        req_y[16*i +: 16] = y;
        req_op[2*i +: 2]  = op;
        req_valid[i]      = 1'b1;
    endtask

    // Drives one request until it is accepted; returns at posedge+1 with the
    // result in the response register.
    task automatic issue(input int i, input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
        bit got = 0;
        set_req(i, op, x, y);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                got = 1;
                break;
            end
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        if (!got) check("grant_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        int gidx;
        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", 32'(rsp_valid), 32'h0);
        check("rst_z", 32'(rsp_z), 32'h0);
        check("rst_id", 32'(rsp_id), 32'h0);
        check("rst_flags", 32'({rsp_carry, rsp_zero, rsp_parity, rsp_sign, rsp_overflow}), 32'h0);

        // Signed overflow on add.
        issue(0, 2'b00, 16'h7FFF, 16'h0001);
        check("t1_z", 32'(rsp_z), 32'h8000);
        check("t1_flags", 32'({rsp_carry, rsp_zero, rsp_parity, rsp_sign, rsp_overflow}), 32'b00011);
        check("t1_id", 32'(rsp_id), 32'h0);

        // Equal operands: zero result, no borrow.
        issue(1, 2'b01, 16'h0005, 16'h0005);
        check("t2_z", 32'(rsp_z), 32'h0);
        check("t2_flags", 32'({rsp_carry, rsp_zero, rsp_parity, rsp_sign, rsp_overflow}), 32'b11100);
        check("t2_sc1", 32'(saved_carry[1]), 32'h1);

        // 32-bit add from req2 with a req0 op between the slices.
        issue(2, 2'b00, 16'hFFFF, 16'h0001);
        check("mp_lo_z", 32'(rsp_z), 32'h0);
        check("mp_lo_c", 32'(rsp_carry), 32'h1);
        issue(0, 2'b00, 16'h1234, 16'h1111);
        check("mp_mid_z", 32'(rsp_z), 32'h2345);
        check("mp_sc2_kept", 32'(saved_carry[2]), 32'h1);
        issue(2, 2'b10, 16'h0001, 16'h0000);
        check("mp_hi_z", 32'(rsp_z), 32'h0002);
        check("mp_hi_id", 32'(rsp_id), 32'h2);

        // Reset to ptr=0, then all four requesters contend.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 2'(i), 16'(16'h1000 * (i + 1)), 16'(i + 3));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            gidx = -1;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) gidx = i;
            check("rr_grant", 32'(gidx), 32'(k % NREQ));
        end
        @(posedge clk); #1;
        req_valid = '0;

        // Backpressure with req0 and req1 pending.
        set_req(0, 2'b00, 16'h0100, 16'h0001);
        set_req(1, 2'b01, 16'h0010, 16'h0001);
        @(negedge clk);
        check("bp_first", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        rsp_ready    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready0", 32'(req_ready), 32'h0);
            check("bp_hold_z", 32'(rsp_z), 32'h0101);
            check("bp_hold_v", 32'(rsp_valid), 32'h1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_refill", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        check("bp_new_z", 32'(rsp_z), 32'h000F);
        check("bp_new_id", 32'(rsp_id), 32'h1);

        // Reset while FULL with requests pending.
        rsp_ready = 1'b0;
        set_req(3, 2'b00, 16'hFFFF, 16'hFFFF);
        set_req(1, 2'b01, 16'h0003, 16'h0001);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_full", 32'(rsp_valid), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        check("mid_rst_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst_sc", 32'(saved_carry), 32'h0);
        check("mid_rst_z", 32'(rsp_z), 32'h0);
        @(negedge clk);
        check("post_rst_grant", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = '0;
        check("post_rst_id", 32'(rsp_id), 32'h1);
        check("post_rst_z", 32'(rsp_z), 32'h0002);

        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/cla16_arbiter.md
Name: cla16_arbiter

Overview:
- Shares one 16-bit carry-lookahead adder datapath among NREQ requesters. Each requester issues add, subtract, add-with-carry or subtract-with-borrow operations.
- Keeps one saved carry per requester, so a requester can chain 16-bit slices into multi-precision arithmetic while other requesters interleave.
- Sits between ALU clients and the adder. Selects a requester round-robin, sequences the operation, and returns a registered result with carry, zero, parity, sign and overflow flags.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, width of requester id; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  requester i has an operation pending.
- req_ready  output  NREQ  one-hot; requester i's operation is accepted this cycle.
- req_x  input  16*NREQ  operand x; requester i uses bits [16i+15:16i].
- req_y  input  16*NREQ  operand y; same slicing as req_x.
- req_op  input  2*NREQ  per-requester opcode: 00 add, 01 sub, 10 adc, 11 sbb.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer takes the response this cycle.
- rsp_id  output  IDW  index of the requester that produced the response.
- rsp_z  output  16  result.
- rsp_carry  output  1  carry out of bit 15.
- rsp_zero  output  1  rsp_z == 0.
- rsp_parity  output  1  even parity: ~^rsp_z.
- rsp_sign  output  1  rsp_z[15].
- rsp_overflow  output  1  signed overflow.
- saved_carry  output  NREQ  per-requester carry state; debug and visibility only.

Behaviour:
- Datapath:
  - Four cla4 instances chained through carry.
  - Effective y: ye = y for add/adc, ye = ~y for sub/sbb.
  - Carry-in: add 0; sub 1; adc and sbb take saved_carry[i] of the granted requester.
  - z = x + ye + cin, modulo 2^16. carry = bit 16.
  - Subtraction convention: carry = 1 means no borrow.
  - overflow = (x15 & ye15 & ~z15) | (~x15 & ~ye15 & z15).
- Response register (single entry, one state bit):
  - EMPTY when rsp_valid = 0; FULL when rsp_valid = 1.
  - can_accept = ~rsp_valid | rsp_ready, so the register can be drained and refilled in the same cycle.
- Arbitration:
  - Round-robin pointer ptr.
  - Grant goes to the first i with req_valid[i], searching ptr, ptr+1, ... with wrap modulo NREQ.
  - req_ready[grant] = can_accept & |req_valid. req_ready is combinational from req_valid, ptr and rsp state.
  - Every other req_ready bit is 0.
- On accept (rising edge):
  - Response register loads z, all flags and id = grant; rsp_valid <= 1.
  - saved_carry[grant] <= carry.
  - ptr <= grant+1, wrapping NREQ-1 to 0.
- Timing:
  - Latency is exactly 1 cycle from accept edge to rsp_valid.
  - Throughput is 1 operation per cycle while rsp_ready = 1.
- If rsp_ready = 1 and there is no accept, rsp_valid <= 0.
- While FULL and rsp_ready = 0:
  - All outputs hold; req_ready = 0; ptr and saved_carry are unchanged.
- A requester must hold req_valid, x, y and op stable until req_ready. The arbiter never drops a held request. Starvation is bounded at NREQ-1 grants to others.
- Requesters that are not granted leave their saved_carry untouched.
- Reset (synchronous, overrides everything that cycle):
  - rsp_valid = 0; rsp_z = 0; all rsp flags 0; rsp_id = 0.
  - ptr = 0; saved_carry = 0; req_ready = 0 during reset.
  - A response pending at reset is discarded.
- Simultaneous drain and accept: the old response is consumed and the new one loaded on the same edge, with no bubble.

Test Plan:
- Reset, then req0 add x=0x7FFF y=0x0001 → next cycle: rsp_z=0x8000, overflow=1, sign=1, carry=0, zero=0, parity=0, rsp_id=0.
- req1 sub x=0x0005 y=0x0005 → rsp_z=0x0000, zero=1, parity=1, carry=1, overflow=0. saved_carry[1] becomes 1.
- Multi-precision, 32-bit 0x0001FFFF + 0x00000001 from req2:
  - add low words (0xFFFF + 0x0001) → z=0x0000, carry=1.
  - then adc high words (0x0001 + 0x0000) → z=0x0002.
  - Interleave a req0 operation between the two slices; saved_carry[2] must be preserved.
- All four req_valid high for 8 cycles with rsp_ready=1 → grant order 0,1,2,3,0,1,2,3, one response per cycle, back-to-back.
- Backpressure: rsp_ready=0 for 3 cycles with req0 and req1 pending → req_ready=0 and rsp outputs stable. When rsp_ready rises, the same-edge drain+accept loads the next result.
- Assert rst while FULL with requests pending → next cycle: rsp_valid=0, saved_carry=0. First grant after reset goes to the lowest pending index.
